// File: rtl/wr_full_ctrl.sv
// wr_full_ctrl: async-FIFO write-side gate with binary/Gray write pointer and registered full/almost_full/count/sticky overflow.
// Latency: write_en is combinational and flags update on the accepting edge; read release takes +2 edges with WR_FULL_CTRL_SYNC_EN.
// Backpressure: while full, wr_req is refused (write_en=0) and sets overflow.
module wr_full_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 2
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              write_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int AF_LEVEL_I = (1 << ADDR_W) - AF_THRESH;
  localparam logic [ADDR_W:0] AF_LEVEL = AF_LEVEL_I[ADDR_W:0];

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] fill_next;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef WR_FULL_CTRL_SYNC_EN
  logic [ADDR_W:0] rq_sync1;
  logic [ADDR_W:0] rq_sync2;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      rq_sync1 <= '0;
      rq_sync2 <= '0;
    end else begin
      rq_sync1 <= rd_ptr_gray;
      rq_sync2 <= rq_sync1;
    end
  end

  assign rq = rq_sync2;
`else
  assign rq = rd_ptr_gray;
`endif

  assign write_en   = wr_req & ~full & ~wr_rst;
  assign wbin_next  = wbin + {{ADDR_W{1'b0}}, write_en};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign rbin       = gray2bin(rq);
  // A stale rq can only lag the true read pointer, so this over-reports fill.
  assign fill_next  = wbin_next - rbin;
  assign wr_addr    = wbin[ADDR_W-1:0];

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= wgray_next;
      // Full when the pointers differ only in the two MSBs of their Gray codes.
      full        <= (wgray_next == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
      almost_full <= (fill_next >= AF_LEVEL);
      wr_count    <= fill_next;
      overflow    <= overflow | (wr_req & full);
    end
  end

endmodule
